serial_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a parallel word through a ready/load handshake and drives it MSB-first onto the single-bit serial line `x` consumed by the team's serial sequence-detector FSMs. It is the driving end of that one-bit `x` interface, replacing hand-written bit sequences in benches and lab top-levels. An optional even-parity bit is appended to each frame.

---
 rtl/serial_tx_pkg.sv | 26 ++
 rtl/tx_shift_reg.sv | 70 +++++++
 rtl/serial_pattern_tx.sv | 119 +++++++++++
 tb/tb_serial_pattern_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// ============================================================================
// Module  : serial_tx_pkg
// Brief   : Shared types and constants for serial_pattern_tx.
//           SERIAL_TX_PARITY_EN selects whether frames carry an even-parity bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } tx_state_t;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

`default_nettype wire

// File: rtl/tx_shift_reg.sv
// ============================================================================
// Module  : tx_shift_reg
// Brief   : Parallel-load, left-shift register with MSB tap and word parity.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             msb,
    output logic             parity
);

    logic [WIDTH-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_en) begin
            sreg_d = load_data;
        end else if (shift_en) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign msb = sreg_q[WIDTH-1];

    generate
        if (PARITY_EN) begin : g_parity
            // Parity is latched with the word so later shifting cannot disturb it.
            logic parity_q, parity_d;

            always_comb begin
                parity_d = parity_q;
                if (load_en) begin
                    parity_d = ^load_data;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    parity_q <= 1'b0;
                end else begin
                    parity_q <= parity_d;
                end
            end

            assign parity = parity_q;
        end else begin : g_no_parity
            assign parity = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
// ============================================================================
// Module  : serial_pattern_tx
// Brief   : Ready/load word transmitter driving a serial line MSB-first.
//           Define SERIAL_TX_PARITY_EN to append an even-parity bit per frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam tx_state_t POST_FRAME = (GAP > 0) ? ST_GAP : ST_IDLE;

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             shift_load;
    logic             shift_en;
    logic             sr_msb;
    logic             sr_parity;

    tx_shift_reg #(
        .WIDTH     (WIDTH),
        .PARITY_EN (PARITY_BITS != 0)
    ) u_shift_reg (
        .clk       (clk),
        .reset     (reset),
        .load_en   (shift_load),
        .load_data (data),
        .shift_en  (shift_en),
        .msb       (sr_msb),
        .parity    (sr_parity)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shift_load = 1'b0;
        shift_en   = 1'b0;
        ready      = 1'b0;
        x          = 1'b0;
        x_valid    = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (load) begin
                    shift_load = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                x         = sr_msb;
                x_valid   = 1'b1;
                shift_en  = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                gap_cnt_d = '0;
                if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    done    = 1'b1;
                    state_d = POST_FRAME;
`endif
                end
            end
            ST_PARITY: begin
                x       = sr_parity;
                x_valid = 1'b1;
                done    = 1'b1;
                state_d = POST_FRAME;
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
// ============================================================================
// Module  : tb_serial_pattern_tx
// Brief   : Randomized bench for serial_pattern_tx (GAP=2 and GAP=0 instances)
//           against a frame-queue reference model; honours SERIAL_TX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_pattern_tx;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    // One beat per cycle: {x, x_valid, done, ready}
    typedef logic [3:0] beat_t;
    typedef beat_t beat_q_t[$];
    localparam beat_t IDLE_BEAT = 4'b0001;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_a, load_b;
    logic [W-1:0] data_a, data_b;
    logic         ready_a, x_a, x_valid_a, done_a;
    logic         ready_b, x_b, x_valid_b, done_b;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(W), .GAP(2)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .load    (load_a),
        .data    (data_a),
        .ready   (ready_a),
        .x       (x_a),
        .x_valid (x_valid_a),
        .done    (done_a)
    );

    serial_pattern_tx #(.WIDTH(W), .GAP(0)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .load    (load_b),
        .data    (data_b),
        .ready   (ready_b),
        .x       (x_b),
        .x_valid (x_valid_b),
        .done    (done_b)
    );

    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    beat_q_t qa, qb;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got={x,v,done,rdy}=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    // Whole frame the line should show from the cycle after acceptance onward.
    function automatic beat_q_t frame(input logic [W-1:0] d, input int gap);
        beat_q_t q;
        int      last = W - 1 + PB;
        for (int i = 0; i < W; i++) begin
            q.push_back({d[W-1-i], 1'b1, (i == last), 1'b0});
        end
        if (PB != 0) begin
            q.push_back({^d, 1'b1, 1'b1, 1'b0});
        end
        for (int i = 0; i < gap; i++) begin
            q.push_back(4'b0000);
        end
        return q;
    endfunction

    task automatic tick();
        logic         r, la, lb;
        logic [W-1:0] da, db;
        beat_t        ea, eb;
        r  = reset;
        la = load_a;
        lb = load_b;
        da = data_a;
        db = data_b;
        @(posedge clk);
        cyc++;
        if (!r) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0) void'(qa.pop_front());
            else if (la)       qa = frame(da, 2);
            if (qb.size() > 0) void'(qb.pop_front());
            else if (lb)       qb = frame(db, 0);
        end
        #1;
        ea = (qa.size() > 0) ? qa[0] : IDLE_BEAT;
        eb = (qb.size() > 0) ? qb[0] : IDLE_BEAT;
        check_eq("gap2", {x_a, x_valid_a, done_a, ready_a}, ea);
        check_eq("gap0", {x_b, x_valid_b, done_b, ready_b}, eb);
    endtask

    initial begin
        reset  = 1'b0;
        load_a = 1'b1;
        load_b = 1'b1;
        data_a = 8'hC3;
        data_b = 8'h3C;
        repeat (3) tick();

        reset  = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        tick();

        // Directed frame, then a load while busy that must be dropped.
        data_a = 8'b1011_0010;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        data_a = W'($urandom);
        repeat (3) tick();
        data_a = 8'hFF;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        repeat (12) tick();

        // Back-to-back frames on the zero-gap instance.
        data_b = 8'hA5;
        load_b = 1'b1;
        repeat (30) tick();
        load_b = 1'b0;
        repeat (12) tick();

        // Reset after the third bit of 8'hF0, then a clean 8'h0F frame.
        data_a = 8'hF0;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        reset  = 1'b1;
        data_a = 8'h0F;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        repeat (12) tick();

        data_a = 8'b1011_0011;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        repeat (12) tick();

        repeat (2000) begin
            load_a = ($urandom_range(0, 3) == 0);
            load_b = ($urandom_range(0, 2) != 0);
            data_a = W'($urandom);
            data_b = W'($urandom);
            reset  = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset  = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        repeat (15) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
